// File: rtl/sine_osc_ctrl.sv
// Start/stop sequencer for an external 3-tap sine oscillator: flush, kick, paced run, sample capture.
// Optional watchdog restart (low amplitude or -128 lockup) when SINE_CTRL_WATCHDOG_EN is defined.
module sine_osc_ctrl #(
  parameter int                 DIV      = 1000,
  parameter logic signed [7:0]  KICK_AMP = 8'sd64,
  parameter int                 WD_MIN   = 4,
  parameter int                 WD_COUNT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic signed [7:0] osc_out,
  output logic signed [7:0] osc_in,
  output logic              osc_step,
  output logic              busy,
  output logic signed [7:0] sample,
  output logic              sample_valid,
  output logic [7:0]        restarts
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] KICK  = 2'd2;
  localparam logic [1:0] RUN   = 2'd3;

  logic [1:0]        state, state_n;
  logic [1:0]        flush_cnt, flush_n;
  logic [15:0]       div_cnt, div_n;
  logic              step_d1;
  logic              halt;
  logic              restart;
  logic              step_n;
  logic signed [7:0] in_n;

  assign busy = (state != IDLE);
  assign halt = (state != IDLE) && stop;

  // osc_step/osc_in are registered from the next state so they line up with the state they belong to.
  always_comb begin
    state_n = state;
    flush_n = flush_cnt;
    div_n   = div_cnt;
    case (state)
      IDLE:  if (start && !stop) begin
               state_n = FLUSH;
               flush_n = 2'd0;
             end
      FLUSH: if (flush_cnt == 2'd2) state_n = KICK;
             else                   flush_n = flush_cnt + 2'd1;
      KICK:  begin
               state_n = RUN;
               div_n   = 16'd0;
             end
      default: div_n = (div_cnt == 16'(DIV - 1)) ? 16'd0 : div_cnt + 16'd1;
    endcase
    if (restart) begin
      state_n = FLUSH;
      flush_n = 2'd0;
      div_n   = 16'd0;
    end
    if (halt) begin
      state_n = IDLE;
      div_n   = 16'd0;
    end
    step_n = (state_n == FLUSH) || (state_n == KICK) ||
             ((state_n == RUN) && (div_n == 16'(DIV - 1)));
    in_n   = (state_n == KICK) ? KICK_AMP : 8'sd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      flush_cnt    <= 2'd0;
      div_cnt      <= 16'd0;
      osc_step     <= 1'b0;
      osc_in       <= 8'sd0;
      step_d1      <= 1'b0;
      sample       <= 8'sd0;
      sample_valid <= 1'b0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_n;
      div_cnt   <= div_n;
      osc_step  <= step_n;
      osc_in    <= in_n;
      if (halt) begin
        step_d1      <= 1'b0;
        sample_valid <= 1'b0;
      end else begin
        step_d1      <= osc_step;
        sample_valid <= step_d1;
        if (step_d1) sample <= osc_out;
      end
    end
  end

`ifdef SINE_CTRL_WATCHDOG_EN
  localparam logic signed [7:0] WD_LIM = 8'(WD_MIN);
  logic [15:0] low_cnt, low_nxt;
  logic        cap_run, low_amp;
  logic [7:0]  restart_cnt;

  assign cap_run = (state == RUN) && step_d1 && !halt;
  assign low_amp = (osc_out < WD_LIM) && (osc_out > -WD_LIM);
  assign low_nxt = low_amp ? low_cnt + 16'd1 : 16'd0;
  assign restart = cap_run && ((low_nxt == 16'(WD_COUNT)) || (osc_out == -8'sd128));
  assign restarts = restart_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      low_cnt     <= 16'd0;
      restart_cnt <= 8'd0;
    end else if (restart) begin
      low_cnt <= 16'd0;
      if (restart_cnt != 8'hFF) restart_cnt <= restart_cnt + 8'd1;
    end else if (state != RUN) begin
      low_cnt <= 16'd0;
    end else if (cap_run) begin
      low_cnt <= low_nxt;
    end
  end
`else
  assign restart  = 1'b0;
  assign restarts = 8'd0;
`endif

endmodule

// File: tb/tb_sine_osc_ctrl.sv
// Directed bench for sine_osc_ctrl (DIV=4, WD_COUNT=3) with a timeline model checked every cycle.
module tb_sine_osc_ctrl;
  localparam int DIV      = 4;
  localparam int WD_MIN   = 4;
  localparam int WD_COUNT = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic signed [7:0] osc_out = 8'sd0;
  logic signed [7:0] osc_in;
  logic              osc_step;
  logic              busy;
  logic signed [7:0] sample;
  logic              sample_valid;
  logic [7:0]        restarts;

  sine_osc_ctrl #(.DIV(DIV), .KICK_AMP(8'sd64), .WD_MIN(WD_MIN), .WD_COUNT(WD_COUNT)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .osc_out(osc_out),
    .osc_in(osc_in), .osc_step(osc_step), .busy(busy), .sample(sample),
    .sample_valid(sample_valid), .restarts(restarts)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: cycle k after the start (or restart) cycle t0 fully determines step/kick/busy.
  bit m_act, m_pend, m_prevstep, m_sv;
  int m_t0, m_low, m_rcnt, m_sample;
  int e_step, e_in, e_busy;

  function automatic bit step_at(int k);
    return (k >= 1 && k <= 4) || (k > 4 && ((k - 4) % DIV) == 0);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_act = 0; m_pend = 0; m_sample = 0; m_sv = 0; m_rcnt = 0; m_low = 0;
    end else begin
      m_sv = 0;
      if (m_act && stop) begin
        m_act  = 0;
        m_pend = 0;
      end else begin
        if (m_pend) begin
          m_sample = int'(osc_out);
          m_sv     = 1;
`ifdef SINE_CTRL_WATCHDOG_EN
          if (cyc - 1 - m_t0 >= 5) begin
            if (int'(osc_out) < WD_MIN && int'(osc_out) > -WD_MIN) m_low++;
            else m_low = 0;
            if (m_low == WD_COUNT || int'(osc_out) == -128) begin
              m_t0  = cyc - 1;
              m_low = 0;
              if (m_rcnt < 255) m_rcnt++;
            end
          end
`endif
        end
        m_pend = m_prevstep;
        if (!m_act && start && !stop) begin
          m_act = 1;
          m_t0  = cyc - 1;
          m_low = 0;
        end
      end
    end
    e_busy     = m_act ? 1 : 0;
    e_step     = (m_act && step_at(cyc - m_t0)) ? 1 : 0;
    e_in       = (m_act && (cyc - m_t0) == 4) ? 64 : 0;
    m_prevstep = (e_step != 0);
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("m_step",   int'(osc_step),     e_step);
      chk("m_in",     int'(osc_in),       e_in);
      chk("m_busy",   int'(busy),         e_busy);
      chk("m_sample", int'(sample),       m_sample);
      chk("m_valid",  int'(sample_valid), int'(m_sv));
      chk("m_rst",    int'(restarts),     m_rcnt);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start pulse at cycle 0, then check the hand-derived step/kick timeline.
  task automatic run_timing;
    tick;
    start   = 1'b1;
    osc_out = 8'sd20;
    for (int k = 1; k <= 13; k++) begin
      tick;
      start   = 1'b0;
      osc_out = (k == 5) ? 8'sd5 : 8'(20 + k);
      @(negedge clk);
      chk("t_step", int'(osc_step), (k inside {1, 2, 3, 4, 8, 12}) ? 1 : 0);
      chk("t_in",   int'(osc_in),   (k == 4) ? 64 : 0);
      chk("t_busy", int'(busy),     1);
      if (k == 6) begin
        chk("t_sample", int'(sample),       5);
        chk("t_valid",  int'(sample_valid), 1);
      end
    end
    tick;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    @(negedge clk);
    chk("t_idle", int'(busy), 0);
  endtask

  initial begin
    tick;
    @(negedge clk);
    chk("r_busy",  int'(busy),         0);
    chk("r_step",  int'(osc_step),     0);
    chk("r_in",    int'(osc_in),       0);
    chk("r_valid", int'(sample_valid), 0);
    chk("r_rst",   int'(restarts),     0);
    tick;
    reset = 1'b1;

    run_timing();

    // stop at cycle 6
    tick;
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick;
      start = 1'b0;
      stop  = (k == 6);
      @(negedge clk);
      if (k == 7) chk("s_busy", int'(busy), 0);
      if (k >= 7) begin
        chk("s_step", int'(osc_step), 0);
        chk("s_in",   int'(osc_in),   0);
      end
    end

    // start and stop together in IDLE
    tick;
    start = 1'b1;
    stop  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick;
      start = 1'b0;
      stop  = 1'b0;
      @(negedge clk);
      chk("b_busy", int'(busy),     0);
      chk("b_step", int'(osc_step), 0);
    end

    // reset mid-run, then identical timing after release
    tick;
    start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick;
      start   = 1'b0;
      osc_out = 8'sd30;
      reset   = (k != 10);
      @(negedge clk);
      if (k == 11) begin
        chk("x_step",   int'(osc_step),     0);
        chk("x_in",     int'(osc_in),       0);
        chk("x_busy",   int'(busy),         0);
        chk("x_sample", int'(sample),       0);
        chk("x_valid",  int'(sample_valid), 0);
        chk("x_rst",    int'(restarts),     0);
      end
    end
    run_timing();

    // watchdog: osc_out stuck at 0, then a -128 lockup
    tick;
    start   = 1'b1;
    osc_out = 8'sd0;
    for (int k = 1; k <= 22; k++) begin
      tick;
      start   = 1'b0;
      osc_out = (k == 18) ? -8'sd128 : 8'sd0;
      @(negedge clk);
`ifdef SINE_CTRL_WATCHDOG_EN
      if (k == 13) chk("w_rst0", int'(restarts), 0);
      if (k == 14) begin
        chk("w_step14", int'(osc_step), 1);
        chk("w_rst1",   int'(restarts), 1);
      end
      if (k == 17) chk("w_kick", int'(osc_in), 64);
      if (k == 19) begin
        chk("w_step19", int'(osc_step), 1);
        chk("w_rst2",   int'(restarts), 2);
      end
      if (k == 22) chk("w_kick2", int'(osc_in), 64);
`else
      if (k == 14) chk("w_nostep", int'(osc_step), 0);
      if (k == 16) chk("w_step16", int'(osc_step), 1);
      if (k == 22) chk("w_rst",    int'(restarts), 0);
`endif
    end
    tick;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    tick;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
